snakes_ladders_multi: RTL and testbench
=======================================

Name: snakes_ladders_multi

Overview:
Parametrised N-player snakes-and-ladders game engine with an automated die and a run-time programmable jump table. Successor to the fixed two-player engine: adds a configurable player count and board size, exact-finish rule, extra turn on a six (three consecutive sixes forfeit the move), a roll-request handshake, and a test-force die path. Sits between the button/debounce front end and the position display/decoder logic.

Parameters:
N_PLAYERS, 4, number of players (2..8)
BOARD_MAX, 100, winning square; positions 0..BOARD_MAX
POS_W, 7, position width; must satisfy 2^POS_W > BOARD_MAX
NUM_JUMPS, 8, jump-table entries (>= 6)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins a new game from IDLE or DONE
roll_req  in  1  request a roll; accepted only when ready=1
force_en  in  1  test mode; die value taken from force_val
force_val  in  3  forced die value; legal range 1..6
cfg_we  in  1  jump-table write strobe
cfg_idx  in  clog2(NUM_JUMPS)  entry index
cfg_from  in  POS_W  jump source square; 0 invalidates the entry
cfg_to  in  POS_W  jump destination square
ready  out  1  high in WAIT_ROLL
cur_player  out  3  player whose turn it is
last_roll  out  3  most recent die value
roll_valid  out  1  one-cycle pulse when last_roll updates
pos_flat  out  N_PLAYERS*POS_W  player i position at bits [i*POS_W +: POS_W]
game_over  out  1  high in DONE
winner  out  3  winning player index; valid while game_over=1

Behaviour:
- Reset (synchronous, active-high, clk rising edge): state IDLE; all positions 0; cur_player 0; last_roll 0; roll_valid 0; game_over 0; winner 0; six counter 0; die counter 1.
- Reset also reloads the default jump table: 9->31, 28->84, 63->81, 87->36, 17->7, 62->19. All other entries are invalid (from=0).
- Reset asserted mid-game aborts the game immediately. No partial move is committed.
- Die: a free-running counter cycles 1,2,...,6,1 and advances every clk in every state.
- Die value at acceptance: force_val if force_en=1 and force_val is in 1..6; otherwise the counter value.
- cfg_we is honoured only in IDLE or DONE and is ignored in all other states. Entries with from=0, from>=BOARD_MAX, or to>BOARD_MAX are stored as invalid.
- FSM states: IDLE, WAIT_ROLL, MOVE, JUMP, CHECK, DONE.
- IDLE: on start, go to WAIT_ROLL. Clear positions, cur_player and the six counter.
- WAIT_ROLL: ready=1. On roll_req (cycle T): capture the die into last_roll, go to MOVE. roll_valid=1 during cycle T+1.
- MOVE (T+1): target = pos + roll, computed at POS_W+1 bits. Count sixes for the current player:
  - die==6 increments the six counter.
  - If the six counter reaches 3: no move, counter cleared, go to CHECK.
  - If target > BOARD_MAX: no move (exact finish required).
- JUMP (T+2): write the position. If the target matches a valid entry's from, write that entry's to; the lowest index wins on multiple matches. Otherwise write target. Jumps never chain. The new position is visible on pos_flat from T+3.
- CHECK (T+3):
  - Position == BOARD_MAX: winner=cur_player, go to DONE.
  - Else if die==6 and the move was not forfeited: same player, go to WAIT_ROLL.
  - Else: clear the six counter, cur_player = (cur_player+1) wrapping at N_PLAYERS-1 to 0, go to WAIT_ROLL.
- DONE: game_over=1. Positions and winner hold. roll_req is ignored. start restarts exactly as from IDLE; the jump table is kept.
- start outside IDLE/DONE is ignored. roll_req outside WAIT_ROLL is ignored; it is not queued.
- Simultaneous start and cfg_we in IDLE: the cfg write is performed and the game starts.

Test Plan:
- Reset, start, force_en=1, force_val=3 -> player 0 pos 3 at T+3; cur_player=1; roll_valid pulses once, at T+1.
- Player 0 at 5, force 4 -> lands on 9 -> pos 31. Player 0 at 13, force 4 -> lands on 17 -> pos 7.
- Player at 97, force 5 -> pos stays 97, turn passes. Then force 3 from 97 -> pos 100, game_over=1, winner=that player. A later roll_req causes no change.
- Force 6, 6, 6 from 0 -> pos 6, then 12, then stays 12 with turn passing and the six counter cleared. Force 6 then 2 -> same player rolls twice, pos +8.
- In IDLE, write idx 6 = 50->2, then start. Landing on 50 -> pos 2. A cfg_we issued during WAIT_ROLL leaves the table unchanged.
- N_PLAYERS=3: turn order wraps 0,1,2,0. Reset asserted in MOVE -> all outputs return to reset values the next cycle and the default table is restored.

Source files
------------

// File: rtl/snakes_ladders_multi.sv
// N-player snakes-and-ladders engine: free-running die, programmable jump table, exact finish, extra turn on six.
// A roll accepted in cycle T shows roll_valid at T+1 and the new position at T+3; roll_req outside WAIT_ROLL is dropped.
module snakes_ladders_multi #(
    parameter int N_PLAYERS = 4,
    parameter int BOARD_MAX = 100,
    parameter int POS_W     = 7,
    parameter int NUM_JUMPS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         roll_req,
    input  logic                         force_en,
    input  logic [2:0]                   force_val,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_JUMPS)-1:0] cfg_idx,
    input  logic [POS_W-1:0]             cfg_from,
    input  logic [POS_W-1:0]             cfg_to,
    output logic                         ready,
    output logic [2:0]                   cur_player,
    output logic [2:0]                   last_roll,
    output logic                         roll_valid,
    output logic [N_PLAYERS*POS_W-1:0]   pos_flat,
    output logic                         game_over,
    output logic [2:0]                   winner
);
    localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam logic [POS_W:0]   BMAX   = (POS_W+1)'(BOARD_MAX);
    localparam logic [POS_W-1:0] BMAX_P = POS_W'(BOARD_MAX);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MOVE, S_JUMP, S_CHECK, S_DONE} state_t;

    state_t           state;
    logic [POS_W-1:0] pos      [N_PLAYERS];
    logic [POS_W-1:0] jmp_from [NUM_JUMPS];
    logic [POS_W-1:0] jmp_to   [NUM_JUMPS];
    logic [2:0]       die_cnt;
    logic [1:0]       six_cnt;
    logic [POS_W:0]   target;
    logic             skip;
    logic             forfeit;

    logic [PW-1:0]    cur_idx;
    logic [POS_W:0]   move_tgt;
    logic [POS_W-1:0] jump_dst;
    logic [2:0]       die_now;
    logic [2:0]       next_player;
    logic             cfg_ok;

    assign cur_idx     = cur_player[PW-1:0];
    assign move_tgt    = {1'b0, pos[cur_idx]} + {{(POS_W-2){1'b0}}, last_roll};
    assign die_now     = (force_en && force_val != 3'd0 && force_val != 3'd7) ? force_val : die_cnt;
    assign next_player = (cur_player == 3'(N_PLAYERS-1)) ? 3'd0 : cur_player + 3'd1;
    assign cfg_ok      = (cfg_from != '0) && (cfg_from < BMAX_P) && (cfg_to <= BMAX_P);
    assign ready       = (state == S_WAIT);
    assign game_over   = (state == S_DONE);

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_flat
        assign pos_flat[g*POS_W +: POS_W] = pos[g];
    end

    // Scan high-to-low so the lowest matching index ends up winning.
    always_comb begin
        jump_dst = target[POS_W-1:0];
        for (int i = NUM_JUMPS-1; i >= 0; i--) begin
            if (jmp_from[i] != '0 && {1'b0, jmp_from[i]} == target)
                jump_dst = jmp_to[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cur_player <= 3'd0;
            last_roll  <= 3'd0;
            roll_valid <= 1'b0;
            winner     <= 3'd0;
            die_cnt    <= 3'd1;
            six_cnt    <= 2'd0;
            target     <= '0;
            skip       <= 1'b0;
            forfeit    <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) pos[i] <= '0;
            for (int i = 0; i < NUM_JUMPS; i++) begin
                jmp_from[i] <= '0;
                jmp_to[i]   <= '0;
            end
            jmp_from[0] <= POS_W'(9);  jmp_to[0] <= POS_W'(31);
            jmp_from[1] <= POS_W'(28); jmp_to[1] <= POS_W'(84);
            jmp_from[2] <= POS_W'(63); jmp_to[2] <= POS_W'(81);
            jmp_from[3] <= POS_W'(87); jmp_to[3] <= POS_W'(36);
            jmp_from[4] <= POS_W'(17); jmp_to[4] <= POS_W'(7);
            jmp_from[5] <= POS_W'(62); jmp_to[5] <= POS_W'(19);
        end else begin
            die_cnt    <= (die_cnt == 3'd6) ? 3'd1 : die_cnt + 3'd1;
            roll_valid <= 1'b0;

            // Invalid entries are stored with from=0 so the lookup never matches them.
            if (cfg_we && (state == S_IDLE || state == S_DONE)) begin
                jmp_from[cfg_idx] <= cfg_ok ? cfg_from : '0;
                jmp_to[cfg_idx]   <= cfg_ok ? cfg_to   : '0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        for (int i = 0; i < N_PLAYERS; i++) pos[i] <= '0;
                        cur_player <= 3'd0;
                        six_cnt    <= 2'd0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (roll_req) begin
                        last_roll  <= die_now;
                        roll_valid <= 1'b1;
                        state      <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    target  <= move_tgt;
                    skip    <= (move_tgt > BMAX);
                    forfeit <= 1'b0;
                    state   <= S_JUMP;
                    if (last_roll == 3'd6) begin
                        if (six_cnt == 2'd2) begin
                            six_cnt <= 2'd0;
                            forfeit <= 1'b1;
                            state   <= S_CHECK;
                        end else begin
                            six_cnt <= six_cnt + 2'd1;
                        end
                    end
                end
                S_JUMP: begin
                    if (!skip) pos[cur_idx] <= jump_dst;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (pos[cur_idx] == BMAX_P) begin
                        winner <= cur_player;
                        state  <= S_DONE;
                    end else if (last_roll == 3'd6 && !forfeit) begin
                        state <= S_WAIT;
                    end else begin
                        six_cnt    <= 2'd0;
                        cur_player <= next_player;
                        state      <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snakes_ladders_multi.sv
// Self-checking bench for snakes_ladders_multi: directed scenarios plus random play against a rule-level game model.
module tb_snakes_ladders_multi;
    logic        clk = 1'b0;
    logic        reset, start, roll_req, force_en, cfg_we;
    logic [2:0]  force_val, cfg_idx;
    logic [6:0]  cfg_from, cfg_to;

    logic        ready, roll_valid, game_over;
    logic [2:0]  cur_player, last_roll, winner;
    logic [27:0] pos_flat;

    logic        ready_3, roll_valid_3, game_over_3;
    logic [2:0]  cur_player_3, last_roll_3, winner_3;
    logic [20:0] pos_flat_3;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    int m_pos [4];
    int m_from [8];
    int m_to [8];
    int m_cur, m_six, m_win, m_last;
    bit m_over;

    snakes_ladders_multi #(.N_PLAYERS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .roll_req(roll_req),
        .force_en(force_en), .force_val(force_val), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_from(cfg_from), .cfg_to(cfg_to), .ready(ready), .cur_player(cur_player),
        .last_roll(last_roll), .roll_valid(roll_valid), .pos_flat(pos_flat),
        .game_over(game_over), .winner(winner)
    );

    snakes_ladders_multi #(.N_PLAYERS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .roll_req(roll_req),
        .force_en(force_en), .force_val(force_val), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_from(cfg_from), .cfg_to(cfg_to), .ready(ready_3), .cur_player(cur_player_3),
        .last_roll(last_roll_3), .roll_valid(roll_valid_3), .pos_flat(pos_flat_3),
        .game_over(game_over_3), .winner(winner_3)
    );

    always #5 clk = ~clk;

    // Die counter reference: value seen in a cycle is (cycles since reset mod 6) + 1.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic void m_defaults();
        for (int i = 0; i < 8; i++) begin m_from[i] = 0; m_to[i] = 0; end
        m_from[0] = 9;  m_to[0] = 31;
        m_from[1] = 28; m_to[1] = 84;
        m_from[2] = 63; m_to[2] = 81;
        m_from[3] = 87; m_to[3] = 36;
        m_from[4] = 17; m_to[4] = 7;
        m_from[5] = 62; m_to[5] = 19;
    endfunction

    function automatic void m_cfg(input int idx, input int f, input int t);
        if (f == 0 || f >= 100 || t > 100) begin m_from[idx] = 0; m_to[idx] = 0; end
        else begin m_from[idx] = f; m_to[idx] = t; end
    endfunction

    function automatic void m_start();
        for (int i = 0; i < 4; i++) m_pos[i] = 0;
        m_cur = 0; m_six = 0; m_over = 0;
    endfunction

    function automatic void m_reset();
        m_start();
        m_win = 0; m_last = 0;
        m_defaults();
    endfunction

    function automatic int m_lookup(input int t);
        for (int i = 0; i < 8; i++)
            if (m_from[i] != 0 && m_from[i] == t) return m_to[i];
        return t;
    endfunction

    function automatic void m_roll(input int die);
        m_last = die;
        if (die == 6 && m_six == 2) begin
            m_six = 0;
            m_cur = (m_cur + 1) % 4;
            return;
        end
        if (die == 6) m_six++;
        if (m_pos[m_cur] + die <= 100) m_pos[m_cur] = m_lookup(m_pos[m_cur] + die);
        if (m_pos[m_cur] == 100) begin
            m_over = 1;
            m_win  = m_cur;
        end else if (die != 6) begin
            m_six = 0;
            m_cur = (m_cur + 1) % 4;
        end
    endfunction

    function automatic logic [27:0] m_flat();
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[i*7 +: 7] = 7'(m_pos[i]);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; roll_req = 1'b0; force_en = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic do_cfg(input int idx, input int f, input int t);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_from = 7'(f); cfg_to = 7'(t);
        @(negedge clk);
        cfg_we = 1'b0;
        m_cfg(idx, f, t);
    endtask

    task automatic do_start(input bit we, input int idx, input int f, input int t);
        @(negedge clk);
        start = 1'b1; cfg_we = we; cfg_idx = 3'(idx); cfg_from = 7'(f); cfg_to = 7'(t);
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        if (we) m_cfg(idx, f, t);
        m_start();
    endtask

    task automatic roll(input int fv, input bit fen);
        int die, mover;
        logic [27:0] ef;
        @(negedge clk);
        roll_req = 1'b1; force_en = fen; force_val = 3'(fv);
        die   = (fen && fv >= 1 && fv <= 6) ? fv : (cyc % 6) + 1;
        mover = m_cur;
        @(negedge clk);
        roll_req = 1'b0; force_en = 1'b0;
        n_tests++;
        if (roll_valid !== 1'b1 || last_roll !== 3'(die)) begin
            n_fail++;
            $display("FAIL roll_t1: roll_valid=%0b last_roll=%0d, required 1 and %0d", roll_valid, last_roll, die);
        end
        m_roll(die);
        @(negedge clk);
        n_tests++;
        if (roll_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL roll_t2: roll_valid=%0b, required 0", roll_valid);
        end
        @(negedge clk);
        ef = m_flat();
        n_tests++;
        if (pos_flat[mover*7 +: 7] !== ef[mover*7 +: 7]) begin
            n_fail++;
            $display("FAIL pos_t3: player %0d pos=%0d, required %0d", mover, pos_flat[mover*7 +: 7], ef[mover*7 +: 7]);
        end
        @(negedge clk);
        n_tests++;
        if (pos_flat !== ef || cur_player !== 3'(m_cur) || game_over !== m_over ||
            ready !== !m_over || (m_over && winner !== 3'(m_win))) begin
            n_fail++;
            $display("FAIL settle: pos=%h cur=%0d over=%0b rdy=%0b win=%0d, required pos=%h cur=%0d over=%0b win=%0d",
                     pos_flat, cur_player, game_over, ready, winner, ef, m_cur, m_over, m_win);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (ready !== 1'b0 || cur_player !== 3'd0 || last_roll !== 3'd0 || roll_valid !== 1'b0 ||
            pos_flat !== 28'd0 || game_over !== 1'b0 || winner !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%0b cur=%0d roll=%0d rv=%0b pos=%h over=%0b win=%0d, required all 0",
                     ready, cur_player, last_roll, roll_valid, pos_flat, game_over, winner);
        end
        n_tests++;
        if (ready_3 !== 1'b0 || cur_player_3 !== 3'd0 || pos_flat_3 !== 21'd0 || game_over_3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state3: rdy=%0b cur=%0d pos=%h over=%0b, required all 0",
                     ready_3, cur_player_3, pos_flat_3, game_over_3);
        end
    endtask

    task automatic test_basic();
        do_reset();
        do_start(1'b0, 0, 0, 0);
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL start_ready: ready=%0b, required 1", ready); end
        roll(3, 1'b1);
        n_tests++;
        if (pos_flat[6:0] !== 7'd3 || cur_player !== 3'd1) begin
            n_fail++;
            $display("FAIL basic_move: pos0=%0d cur=%0d, required 3 and 1", pos_flat[6:0], cur_player);
        end
    endtask

    task automatic test_ladders();
        do_reset();
        do_start(1'b0, 0, 0, 0);
        roll(5, 1'b1);
        for (int k = 0; k < 3; k++) roll(1, 1'b1);
        roll(4, 1'b1);
        n_tests++;
        if (pos_flat[6:0] !== 7'd31) begin n_fail++; $display("FAIL ladder_9: pos0=%0d, required 31", pos_flat[6:0]); end
        do_reset();
        do_start(1'b0, 0, 0, 0);
        roll(6, 1'b1);
        roll(6, 1'b1);
        roll(1, 1'b1);
        for (int k = 0; k < 3; k++) roll(1, 1'b1);
        roll(4, 1'b1);
        n_tests++;
        if (pos_flat[6:0] !== 7'd7) begin n_fail++; $display("FAIL snake_17: pos0=%0d, required 7", pos_flat[6:0]); end
    endtask

    task automatic test_exact_finish();
        do_reset();
        do_cfg(7, 2, 97);
        do_start(1'b0, 0, 0, 0);
        roll(1, 1'b1); roll(2, 1'b1); roll(1, 1'b1); roll(1, 1'b1);
        roll(3, 1'b1);
        roll(5, 1'b1);
        n_tests++;
        if (pos_flat[13:7] !== 7'd97 || cur_player !== 3'd2) begin
            n_fail++;
            $display("FAIL overshoot: pos1=%0d cur=%0d, required 97 and 2", pos_flat[13:7], cur_player);
        end
        roll(3, 1'b1); roll(3, 1'b1); roll(3, 1'b1);
        roll(3, 1'b1);
        n_tests++;
        if (game_over !== 1'b1 || winner !== 3'd1 || pos_flat[13:7] !== 7'd100) begin
            n_fail++;
            $display("FAIL finish: over=%0b win=%0d pos1=%0d, required 1, 1, 100", game_over, winner, pos_flat[13:7]);
        end
        @(negedge clk);
        roll_req = 1'b1; force_en = 1'b1; force_val = 3'd2;
        @(negedge clk);
        roll_req = 1'b0; force_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (roll_valid !== 1'b0) begin n_fail++; $display("FAIL done_ignore_rv: roll_valid=%0b, required 0", roll_valid); end
            @(negedge clk);
        end
        n_tests++;
        if (pos_flat !== m_flat() || last_roll !== 3'd3 || game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: pos=%h roll=%0d over=%0b, required %h, 3, 1", pos_flat, last_roll, game_over, m_flat());
        end
        do_start(1'b0, 0, 0, 0);
        roll(2, 1'b1);
        n_tests++;
        if (pos_flat[6:0] !== 7'd97) begin n_fail++; $display("FAIL restart_table: pos0=%0d, required 97", pos_flat[6:0]); end
    endtask

    task automatic test_sixes();
        do_reset();
        do_start(1'b0, 0, 0, 0);
        roll(6, 1'b1); roll(6, 1'b1); roll(6, 1'b1);
        n_tests++;
        if (pos_flat[6:0] !== 7'd12 || cur_player !== 3'd1) begin
            n_fail++;
            $display("FAIL three_sixes: pos0=%0d cur=%0d, required 12 and 1", pos_flat[6:0], cur_player);
        end
        roll(6, 1'b1); roll(2, 1'b1);
        n_tests++;
        if (pos_flat[13:7] !== 7'd8 || cur_player !== 3'd2) begin
            n_fail++;
            $display("FAIL six_bonus: pos1=%0d cur=%0d, required 8 and 2", pos_flat[13:7], cur_player);
        end
    endtask

    task automatic test_cfg();
        do_reset();
        do_cfg(7, 1, 44);
        do_start(1'b1, 6, 50, 2);
        roll(1, 1'b1);
        for (int k = 0; k < 3; k++) roll(2, 1'b1);
        roll(6, 1'b1);
        n_tests++;
        if (pos_flat[6:0] !== 7'd2 || cur_player !== 3'd0) begin
            n_fail++;
            $display("FAIL cfg_entry: pos0=%0d cur=%0d, required 2 and 0", pos_flat[6:0], cur_player);
        end
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_from = 7'd5; cfg_to = 7'd90;
        @(negedge clk);
        cfg_we = 1'b0;
        roll(3, 1'b1);
        n_tests++;
        if (pos_flat[6:0] !== 7'd5) begin n_fail++; $display("FAIL cfg_locked: pos0=%0d, required 5", pos_flat[6:0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_cfg(0, 9, 60);
        do_start(1'b0, 0, 0, 0);
        @(negedge clk);
        roll_req = 1'b1; force_en = 1'b1; force_val = 3'd3;
        @(negedge clk);
        roll_req = 1'b0; force_en = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        n_tests++;
        if (ready !== 1'b0 || cur_player !== 3'd0 || last_roll !== 3'd0 || roll_valid !== 1'b0 ||
            pos_flat !== 28'd0 || game_over !== 1'b0 || winner !== 3'd0 || pos_flat_3 !== 21'd0) begin
            n_fail++;
            $display("FAIL mid_reset: rdy=%0b cur=%0d roll=%0d rv=%0b pos=%h pos3=%h, required all 0",
                     ready, cur_player, last_roll, roll_valid, pos_flat, pos_flat_3);
        end
        do_start(1'b0, 0, 0, 0);
        roll(6, 1'b1);
        roll(3, 1'b1);
        n_tests++;
        if (pos_flat[6:0] !== 7'd31) begin n_fail++; $display("FAIL default_restore: pos0=%0d, required 31", pos_flat[6:0]); end
    endtask

    task automatic test_wrap3();
        int p3 [3];
        logic [20:0] e3;
        do_reset();
        do_start(1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) p3[i] = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            roll_req = 1'b1; force_en = 1'b1; force_val = 3'd1;
            @(negedge clk);
            roll_req = 1'b0; force_en = 1'b0;
            repeat (3) @(negedge clk);
            p3[k % 3]++;
            for (int i = 0; i < 3; i++) e3[i*7 +: 7] = 7'(p3[i]);
            n_tests++;
            if (cur_player_3 !== 3'((k + 1) % 3) || pos_flat_3 !== e3) begin
                n_fail++;
                $display("FAIL wrap3: step %0d cur=%0d pos=%h, required cur=%0d pos=%h",
                         k, cur_player_3, pos_flat_3, (k + 1) % 3, e3);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        do_start(1'b0, 0, 0, 0);
        for (int r = 0; r < 300; r++) begin
            if (m_over) begin
                n_tests++;
                if (game_over !== 1'b1 || winner !== 3'(m_win)) begin
                    n_fail++;
                    $display("FAIL rand_done: over=%0b win=%0d, required 1 and %0d", game_over, winner, m_win);
                end
                do_cfg(int'($urandom % 8), int'($urandom % 128), int'($urandom % 128));
                do_start(1'b0, 0, 0, 0);
            end else begin
                roll(int'($urandom % 8), 1'($urandom % 2));
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; roll_req = 1'b0; force_en = 1'b0; force_val = 3'd0;
        cfg_we = 1'b0; cfg_idx = 3'd0; cfg_from = 7'd0; cfg_to = 7'd0;
        m_reset();
        test_reset();
        test_basic();
        test_ladders();
        test_exact_finish();
        test_sixes();
        test_cfg();
        test_reset_mid();
        test_wrap3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
